// File: rtl/pwm_fade_seq.sv
// Four-channel PWM duty fader with a registered write port to the PWM peripheral.
// CPU writes pass straight through; otherwise pending duty updates are sent one per cycle, round-robin.
module pwm_fade_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we_i,
    input  logic [31:0] cfg_addr_i,
    input  logic [31:0] cfg_data_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  busy_o
);
    localparam int unsigned NumCh = 4;

    logic [31:0] target_q [NumCh];
    logic [31:0] target_d [NumCh];
    logic [31:0] step_q   [NumCh];
    logic [31:0] step_d   [NumCh];
    logic [31:0] ivl_q    [NumCh];
    logic [31:0] ivl_d    [NumCh];
    logic [31:0] cur_q    [NumCh];
    logic [31:0] cur_d    [NumCh];
    logic [31:0] timer_q  [NumCh];
    logic [31:0] timer_d  [NumCh];

    logic [NumCh-1:0] enable_q, enable_d;
    logic [NumCh-1:0] pending_q, pending_d;
    logic [NumCh-1:0] upd;
    logic [1:0]       last_q, last_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;

    logic [3:0] cfg_sel;
    logic [3:0] cfg_ch;
    logic       gnt_vld;
    logic [1:0] gnt_ch;
    logic       unused_cfg;

    assign cfg_sel    = cfg_addr_i[23:20];
    assign cfg_ch     = cfg_addr_i[19:16];
    assign unused_cfg = ^{cfg_addr_i[31:24], cfg_addr_i[15:0]};

    always_comb begin : chan_next
        logic [31:0] ivl_eff;
        logic [31:0] step_eff;
        logic        tick;
        logic        wr;
        ivl_eff  = '0;
        step_eff = '0;
        tick     = 1'b0;
        wr       = 1'b0;
        target_d = target_q;
        step_d   = step_q;
        ivl_d    = ivl_q;
        cur_d    = cur_q;
        timer_d  = timer_q;
        enable_d = enable_q;
        upd      = '0;
        for (int unsigned ch = 0; ch < NumCh; ch++) begin
            ivl_eff  = (ivl_q[ch] == '0) ? 32'd1 : ivl_q[ch];
            step_eff = (step_q[ch] == '0) ? 32'd1 : step_q[ch];
            tick     = timer_q[ch] >= ivl_eff - 32'd1;
            wr       = cfg_we_i && (cfg_ch[3:2] == 2'b00) && (cfg_ch[1:0] == 2'(ch));
            timer_d[ch] = tick ? 32'd0 : timer_q[ch] + 32'd1;

            // Saturate on the difference so the step can never wrap past the target.
            if (enable_q[ch] && tick && (cur_q[ch] != target_q[ch])) begin
                upd[ch] = 1'b1;
                if (target_q[ch] > cur_q[ch]) begin
                    cur_d[ch] = (step_eff >= target_q[ch] - cur_q[ch]) ? target_q[ch]
                                                                      : cur_q[ch] + step_eff;
                end else begin
                    cur_d[ch] = (step_eff >= cur_q[ch] - target_q[ch]) ? target_q[ch]
                                                                      : cur_q[ch] - step_eff;
                end
            end

            if (wr) begin
                case (cfg_sel)
                    4'd0: begin
                        target_d[ch] = cfg_data_i;
                        timer_d[ch]  = '0;
                    end
                    4'd1: step_d[ch] = cfg_data_i;
                    4'd2: begin
                        ivl_d[ch]   = cfg_data_i;
                        timer_d[ch] = '0;
                    end
                    4'd3: enable_d[ch] = cfg_data_i[0];
                    4'd4: begin
                        cur_d[ch] = cfg_data_i;
                        upd[ch]   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin : arb
        logic [1:0] cand;
        cand    = '0;
        gnt_vld = 1'b0;
        gnt_ch  = last_q;
        for (int unsigned i = 1; i <= NumCh; i++) begin
            cand = last_q + 2'(i);
            if (!gnt_vld && pending_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    always_comb begin : out_next
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        last_d    = last_q;
        pending_d = pending_q | upd;
        if (cpu_we_i) begin
            we_d   = 1'b1;
            addr_d = cpu_addr_i;
            data_d = cpu_data_i;
        end else if (gnt_vld) begin
            we_d   = 1'b1;
            addr_d = 32'h0010_0000 | {14'b0, gnt_ch, 16'b0};
            data_d = cur_q[gnt_ch];
            last_d = gnt_ch;
            // A fresh update in the grant cycle keeps the channel pending.
            pending_d[gnt_ch] = upd[gnt_ch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumCh; i++) begin
                target_q[i] <= '0;
                step_q[i]   <= '0;
                ivl_q[i]    <= '0;
                cur_q[i]    <= '0;
                timer_q[i]  <= '0;
            end
            enable_q  <= '0;
            pending_q <= '0;
            last_q    <= 2'd3;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            target_q  <= target_d;
            step_q    <= step_d;
            ivl_q     <= ivl_d;
            cur_q     <= cur_d;
            timer_q   <= timer_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int unsigned ch = 0; ch < NumCh; ch++) begin
            busy_o[ch] = (enable_q[ch] && (cur_q[ch] != target_q[ch])) || pending_q[ch];
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Scoreboarded bench for pwm_fade_seq: directed stimulus queues expected PWM writes,
// a negedge monitor pops and compares every write the block emits.
module tb_pwm_fade_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_data = '0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  busy;

    pwm_fade_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we_i   (cfg_we),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_data),
        .cpu_we_i   (cpu_we),
        .cpu_addr_i (cpu_addr),
        .cpu_data_i (cpu_data),
        .we_o       (we),
        .addr_o     (addr),
        .data_o     (data),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;  // cycles since previous write; 0 = not checked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_wr = 0;
    int   wr_count = 0;
    int   wr_mark = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr=%h data=%h exp none", addr, data);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", addr, mon_e.addr);
                chk("wr_data", data, mon_e.data);
                if (mon_e.gap != 0) chk("wr_gap", 32'(cyc - last_wr), 32'(mon_e.gap));
            end
            last_wr = cyc;
        end
    end

    task automatic push_raw(input logic [31:0] a, input logic [31:0] d, input int gap);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic push(input int ch, input logic [31:0] d, input int gap);
        push_raw(32'h0010_0000 | (32'(ch) << 16), d, gap);
    endtask

    task automatic cfg(input int sel, input int ch, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = {8'h00, 4'(sel), 4'(ch), 16'h0000};
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_busy", {28'b0, busy}, 32'd0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d writes outstanding exp 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle_check(input string name, input int n);
        wr_mark = wr_count;
        repeat (n) @(posedge clk);
        #1;
        chk(name, 32'(wr_count - wr_mark), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fade up on ch0: 10, 20, 30, 35 every 4 cycles.
        do_reset();
        push(0, 32'd10, 0);
        push(0, 32'd20, 4);
        push(0, 32'd30, 4);
        push(0, 32'd35, 4);
        cfg(1, 0, 32'd10);
        cfg(2, 0, 32'd4);
        cfg(0, 0, 32'd35);
        chk("up_busy_off", {28'b0, busy}, 32'd0);
        cfg(3, 0, 32'd1);
        chk("up_busy_on", {28'b0, busy}, 32'd1);
        drain(60);
        chk("up_busy_done", {28'b0, busy}, 32'd0);

        // Fade down with saturation on ch1 from a direct load of 100.
        do_reset();
        push(1, 32'd100, 0);
        push(1, 32'd60, 2);
        push(1, 32'd20, 1);
        push(1, 32'd5, 1);
        cfg(0, 1, 32'd5);
        cfg(1, 1, 32'd40);
        cfg(2, 1, 32'd1);
        cfg(4, 1, 32'd100);
        cfg(3, 1, 32'd1);
        drain(30);
        chk("dn_hold_we", {31'b0, we}, 32'd0);
        chk("dn_hold_addr", addr, 32'h0011_0000);
        chk("dn_hold_data", data, 32'd5);
        chk("dn_busy_done", {28'b0, busy}, 32'd0);

        // CPU writes win for three cycles; ch0 then ch2 follow, nothing dropped.
        do_reset();
        for (int i = 0; i < 3; i++) push_raw(32'hA000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i), 0);
        push(0, 32'h11, 1);
        push(2, 32'h22, 1);
        cfg(4, 0, 32'h11);
        cfg_we   = 1'b1;
        cfg_addr = 32'h0042_0000;
        cfg_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            cpu_we   = 1'b1;
            cpu_addr = 32'hA000_0000 + 32'(i);
            cpu_data = 32'hC0DE_0000 + 32'(i);
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
        end
        cpu_we = 1'b0;
        drain(20);
        chk("arb_busy_done", {28'b0, busy}, 32'd0);

        // All four channels pending at interval 1: grants rotate 0,1,2,3,0,...
        do_reset();
        for (int ch = 0; ch < 4; ch++) begin
            cfg(0, ch, 32'd5);
            cfg(1, ch, 32'd1);
        end
        for (int ch = 0; ch < 4; ch++) push(ch, 32'd1, (ch == 0) ? 0 : 1);
        for (int ch = 0; ch < 4; ch++) push(ch, 32'd5, 1);
        for (int ch = 0; ch < 4; ch++) cfg(3, ch, 32'd1);
        drain(40);
        chk("rr_busy_done", {28'b0, busy}, 32'd0);

        // Step 0 and interval 0 act as 1.
        do_reset();
        push(3, 32'd1, 0);
        push(3, 32'd2, 1);
        push(3, 32'd3, 1);
        cfg(1, 3, 32'd0);
        cfg(2, 3, 32'd0);
        cfg(0, 3, 32'd3);
        cfg(3, 3, 32'd1);
        drain(30);
        chk("z_busy_done", {28'b0, busy}, 32'd0);

        // Near-top fade saturates at 0xFFFF_FFFF without wrapping.
        push(2, 32'hFFFF_FFF0, 0);
        push(2, 32'hFFFF_FFFF, 2);
        cfg(0, 2, 32'hFFFF_FFFF);
        cfg(1, 2, 32'h20);
        cfg(4, 2, 32'hFFFF_FFF0);
        cfg(3, 2, 32'd1);
        drain(30);
        chk("wrap_data", data, 32'hFFFF_FFFF);
        chk("wrap_busy", {28'b0, busy}, 32'd0);

        // Out-of-range channel is ignored.
        cfg(4, 5, 32'h55);
        idle_check("badch_writes", 10);

        // Reset mid-fade abandons the rest of the fade.
        do_reset();
        push(0, 32'd10, 0);
        cfg(1, 0, 32'd10);
        cfg(2, 0, 32'd4);
        cfg(0, 0, 32'd35);
        cfg(3, 0, 32'd1);
        drain(30);
        do_reset();
        idle_check("mid_fade_writes", 40);
        chk("mid_fade_busy", {28'b0, busy}, 32'd0);

        // Reset in the cycle a grant would fire drops that write.
        cfg(4, 1, 32'h77);
        do_reset();
        idle_check("mid_grant_writes", 10);
        chk("mid_grant_busy", {28'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_fade_seq.md
PWM_FADE_SEQ -- requirements
Module: pwm_fade_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-003 SHALL have port cfg_we_i, input, 1 bit, config write strobe for this block's registers.
REQ-004 SHALL have port cfg_addr_i, input, 32 bits, config address: [23:20] register select, [19:16] channel (0-3); other bits ignored.
REQ-005 SHALL have port cfg_data_i, input, 32 bits, config write data.
REQ-006 SHALL have port cpu_we_i, input, 1 bit, CPU pass-through write strobe destined for the PWM peripheral.
REQ-007 SHALL have port cpu_addr_i, input, 32 bits, CPU pass-through address.
REQ-008 SHALL have port cpu_data_i, input, 32 bits, CPU pass-through data.
REQ-009 SHALL have port we_o, output, 1 bit, registered write strobe to the PWM peripheral.
REQ-010 SHALL have port addr_o, output, 32 bits, registered PWM address.
REQ-011 SHALL have port data_o, output, 32 bits, registered PWM data.
REQ-012 SHALL have port busy_o, output, 4 bits, per channel: fade enabled and current duty != target, or an update pending.

Function
REQ-013 SHALL decode config registers per channel ch as: sel 0 target duty; sel 1 step; sel 2 interval (clock ticks); sel 3 control (bit0 = fade enable); sel 4 current duty direct load; other sel values are ignored; channel bits 0-3 only, values >=4 are ignored.
REQ-014 SHALL hold for each channel a free-running 32-bit tick timer counting 0..interval-1, with interval 0 treated as 1.
REQ-015 SHALL, in the cycle the timer equals interval-1 with enable=1 and cur != target, update cur toward target by step: up = min(cur+step, target), down = max(cur-step, target). Step 0 is treated as 1. Comparisons use unsigned target-cur / cur-target differences, so no 32-bit wrap occurs.
REQ-016 SHALL set pending[ch] on every cur update, including sel-4 loads.
REQ-017 SHALL reset the channel timer to 0 on any write to that channel's target or interval.
REQ-018 SHALL leave cur and pending unchanged when enable is cleared; pending updates still drain.
REQ-019 SHALL, each cycle, register one PWM write by priority:
 - cpu_we_i=1: forward cpu_addr_i/cpu_data_i.
 - Else, any pending: grant one channel round-robin, searching from the channel after the last granted, and drive addr_o = 0x0010_0000 | ch<<16 with data_o = cur[ch] as of that cycle.
 - Else: we_o=0.
REQ-020 SHALL clear pending[ch] on grant, except that a same-cycle new update of ch keeps pending set (set wins).
REQ-021 SHALL advance the round-robin pointer only on a sequencer grant; CPU cycles stall, never drop, pending updates.
REQ-022 SHALL, when we_o=0, hold addr_o and data_o at their previous values.
REQ-023 SHALL emit a write one cycle after its pending bit is set at the earliest (one-cycle registered latency).
REQ-024 SHALL, for a config write and a tick update to the same channel in the same cycle, use the new config in the following cycle only; the tick uses old values, and a sel-4 load overrides the tick result.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear all target, step, interval, enable, cur, timers and pending, and set the round-robin pointer so ch0 is searched first.
REQ-026 SHALL drive we_o=0, addr_o=0, data_o=0 and busy_o=0 in the cycle after reset.
REQ-027 SHALL let reset asserted mid-fade or mid-grant abandon all pending writes without emitting them.

Verification
REQ-028 SHALL test a fade up: ch0 step=10, interval=4, target=35, enable=1 -> writes to 0x0010_0000 with data 10, 20, 30, 35 spaced 4 cycles apart; busy_o[0] then falls.
REQ-029 SHALL test a fade down with saturation: ch1 cur loaded 100, target=5, step=40, interval=1 -> data_o 100 (load), 60, 20, 5 at addr 0x0011_0000, never below 5.
REQ-030 SHALL test the arbiter: pending on ch0 and ch2 plus cpu_we_i held high for 3 cycles -> 3 CPU writes forwarded, then ch0, then ch2; none dropped.
REQ-031 SHALL test round-robin: ch0-ch3 continuously pending at interval 1 -> grants rotate 0,1,2,3,0.
REQ-032 SHALL test edge cases: step=0 and interval=0 behave as 1; target=0xFFFF_FFFF with cur=0xFFFF_FFF0 and step=0x20 -> cur becomes 0xFFFF_FFFF with no wrap.
REQ-033 SHALL test reset mid-fade: rst for one cycle during ch0 fade -> no further writes, all outputs 0, and no activity until reconfigured.
